acc_bcd_display: RTL and testbench
==================================

// Module: acc_bcd_display
// PURPOSE
//  Sequential binary-to-BCD converter and 7-segment encoder placed downstream of the accumulator.
//  Takes the 8-bit accumulator value when execute-phase strobe fires; converts by iterative
//  double-dabble (one shift/cycle); drives three registered active-low digit outputs.
//  Replaces the combinational seven_segment path; display updates once per completed conversion.
// PARAMETERS
//  SIGNED_MODE  0  1: acc_value is two's complement; magnitude displayed, neg output flags sign
// PORTS
//  clk        in   1  system clock (divided CPU clock); all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  acc_value  in   8  accumulator value to display
//  acc_valid  in   1  1-cycle strobe: sample acc_value (tied to execute phase)
//  seg1       out  7  hundreds digit, {g,f,e,d,c,b,a}, active-low
//  seg2       out  7  tens digit, same encoding
//  seg3       out  7  units digit, same encoding
//  neg        out  1  1 = displayed value negative (SIGNED_MODE=1 only; else constant 0)
//  busy       out  1  1 while conversion in progress (state != IDLE)
//  done       out  1  1-cycle pulse when seg1..seg3 have just been updated
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; seg1..seg3=7'h7F (blank); neg=0; busy=0; done=0; pending cleared.
//  FSM: IDLE -> SHIFT (8 cycles) -> UPDATE -> IDLE, or UPDATE -> SHIFT if work pending.
//   IDLE: acc_valid=1 at edge E0 -> load operand (magnitude if SIGNED_MODE and bit7=1; sign kept),
//         clear 12-bit BCD scratch, cnt=0, go SHIFT.
//   SHIFT: per edge, for each BCD nibble >=5 add 3, then shift {bcd,operand} left by 1; cnt++.
//          After 8th shift (edge E8) go UPDATE.
//   UPDATE (edge E9): seg1..seg3 and neg loaded from scratch; done=1 for the following cycle.
//  Latency: new digits visible after E9 = 9 clocks after the sampling edge; busy high E0..E9.
//  Magnitude: SIGNED_MODE=1 and bit7=1 -> 8-bit two's-complement negation; -128 -> 128 (9th bit
//  not needed, 8'h80 unsigned = 128). Max result 255 -> 3 BCD digits; scratch never overflows.
//  Strobe while busy (SHIFT or UPDATE): value stored in pending register, pending flag set; later
//  strobes overwrite it (last wins). At UPDATE, if pending or acc_valid: load that value (acc_valid
//  takes priority over pending), clear pending, go straight to SHIFT; done still pulses.
//  Outputs hold between conversions; no display change without a strobe.
//  Reset mid-conversion: scratch discarded; outputs return to blank; no done pulse.
//  Digit encoding (active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 blank=7F.
// CONFIGURATION
//  Macro BCD_BLANK_EN:
//   defined: leading zeros blanked at UPDATE: seg1=7F if hundreds=0; seg2=7F if hundreds=0
//            and tens=0. seg3 always shown (value 0 displays "  0").
//   undefined: all three digits always encoded (value 0 displays "000").
//  Reset value (all blank) is identical in both builds.
// TESTING
//  1. Reset, strobe 8'd255 -> busy 1 for E0..E9; after E9 seg1=24 seg2=12 seg3=12, done pulse 1 cycle.
//  2. Strobe 8'd0 -> BCD_BLANK_EN: seg1=7F seg2=7F seg3=40; undefined: 40/40/40.
//  3. Strobe 8'd7 in SHIFT, then 8'd42, then 8'd199 before E9 -> first result shown,
//     then with no idle cycle 199 (seg1=79 seg2=10 seg3=10); 42 never displayed; two done pulses.
//  4. Strobe 8'd128, assert rst_n=0 at E4 -> segs=7F, busy=0, done never pulses; next strobe
//     8'd9 -> seg3=10 after 9 clocks.
//  5. SIGNED_MODE=1: strobe 8'h80 -> neg=1, digits 1/2/8 (79/24/00); 8'hFF -> neg=1, units 1.
//  6. Strobe 8'd100 at same edge UPDATE loads a pending value -> strobed 100 converted,
//     pending dropped; seg1=79 seg2=40 seg3=40.

Source files
------------

// File: rtl/acc_bcd_display_if.sv
// Display-side bus for acc_bcd_display: accumulator strobe in, registered digits and status out.
// The master side drives the strobe; the slave side is the converter.
interface acc_bcd_display_if;
  logic [7:0] acc_value;
  logic       acc_valid;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic       neg;
  logic       busy;
  logic       done;

  modport master (
    output acc_value, acc_valid,
    input  seg1, seg2, seg3, neg, busy, done
  );

  modport slave (
    input  acc_value, acc_valid,
    output seg1, seg2, seg3, neg, busy, done
  );
endinterface

// File: rtl/acc_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter with registered active-low 7-segment digits.
// Optional build macro BCD_BLANK_EN blanks leading zeros on the hundreds and tens digits.
module acc_bcd_display #(
  parameter bit SIGNED_MODE = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  acc_bcd_display_if.slave bus
);

  localparam logic [6:0] SegBlank = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StUpdate
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] opnd_q, opnd_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       sign_q, sign_d;
  logic [7:0] pend_val_q, pend_val_d;
  logic       pend_q, pend_d;
  logic [6:0] seg1_q, seg1_d;
  logic [6:0] seg2_q, seg2_d;
  logic [6:0] seg3_q, seg3_d;
  logic       neg_q, neg_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // 8-bit negation maps -128 onto 8'h80, which reads correctly as unsigned 128.
  function automatic logic [7:0] magnitude(input logic [7:0] value);
    if (SIGNED_MODE && value[7]) begin
      return 8'(~value + 8'd1);
    end
    return value;
  endfunction

  function automatic logic [3:0] nibble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
  endfunction

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    seg1_d     = seg1_q;
    seg2_d     = seg2_q;
    seg3_d     = seg3_q;
    neg_d      = neg_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.acc_valid) begin
          opnd_d  = magnitude(bus.acc_value);
          sign_d  = SIGNED_MODE && bus.acc_value[7];
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end

      StShift: begin
        if (bus.acc_valid) begin
          pend_val_d = bus.acc_value;
          pend_d     = 1'b1;
        end
        // Adjust every nibble first, then shift the whole {bcd, operand} word left by one.
        bcd_d  = 12'({nibble_adjust(bcd_q[11:8]), nibble_adjust(bcd_q[7:4]),
                      nibble_adjust(bcd_q[3:0]), opnd_q[7]});
        opnd_d = {opnd_q[6:0], 1'b0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StUpdate;
        end
      end

      StUpdate: begin
`ifdef BCD_BLANK_EN
        seg1_d = (bcd_q[11:8] == 4'd0) ? SegBlank : seg_encode(bcd_q[11:8]);
        seg2_d = (bcd_q[11:4] == 8'd0) ? SegBlank : seg_encode(bcd_q[7:4]);
`else
        seg1_d = seg_encode(bcd_q[11:8]);
        seg2_d = seg_encode(bcd_q[7:4]);
`endif
        seg3_d = seg_encode(bcd_q[3:0]);
        neg_d  = SIGNED_MODE && sign_q;
        done_d = 1'b1;

        // A live strobe beats the queued value; either way the queue is emptied.
        if (bus.acc_valid || pend_q) begin
          opnd_d  = magnitude(bus.acc_valid ? bus.acc_value : pend_val_q);
          sign_d  = SIGNED_MODE && (bus.acc_valid ? bus.acc_value[7] : pend_val_q[7]);
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      opnd_q     <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      seg1_q     <= SegBlank;
      seg2_q     <= SegBlank;
      seg3_q     <= SegBlank;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      seg1_q     <= seg1_d;
      seg2_q     <= seg2_d;
      seg3_q     <= seg3_d;
      neg_q      <= neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.seg1 = seg1_q;
  assign bus.seg2 = seg2_q;
  assign bus.seg3 = seg3_q;
  assign bus.neg  = neg_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_acc_bcd_display.sv
// Directed bench for acc_bcd_display: vector table for single conversions plus hand-built
// sequences for queued strobes, strobe/update collision, mid-conversion reset and signed mode.
module tb_acc_bcd_display;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_bcd_display_if u_if ();
  acc_bcd_display_if s_if ();

  acc_bcd_display #(.SIGNED_MODE(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  acc_bcd_display #(.SIGNED_MODE(1'b1)) s_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if)
  );

  typedef struct {
    logic [7:0]  val;
    logic        neg;
    int          mag;
    logic [20:0] segs;
  } vec_t;

  vec_t vecs[11];
  vec_t svecs[5];

  int n_cmp = 0;
  int n_bad = 0;

  int          dn_cnt;
  int          dn_cyc[2];
  logic [20:0] dn_segs[2];
  logic        dn_neg[2];
  int          busy_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Leading-zero blanking applies only in the BCD_BLANK_EN build.
  function automatic logic [20:0] exp_segs(input logic [20:0] full, input int mag);
    logic [20:0] r;
    r = full;
`ifdef BCD_BLANK_EN
    if (mag < 100) r[20:14] = 7'h7F;
    if (mag < 10)  r[13:7]  = 7'h7F;
`else
    if (mag > 255) r = '0;
`endif
    return r;
  endfunction

  // Drive up to three one-cycle strobes at given negedge indices and log every done pulse.
  task automatic run_sched(input bit sel, input int t0, input logic [7:0] v0,
                           input int t1, input logic [7:0] v1,
                           input int t2, input logic [7:0] v2, input int ncyc);
    logic       d, b, vld;
    logic [7:0] val;
    dn_cnt    = 0;
    busy_drop = -1;
    for (int i = 0; i <= ncyc; i++) begin
      @(negedge clk);
      d = sel ? s_if.done : u_if.done;
      b = sel ? s_if.busy : u_if.busy;
      if (d) begin
        if (dn_cnt < 2) begin
          dn_cyc[dn_cnt]  = i;
          dn_segs[dn_cnt] = sel ? {s_if.seg1, s_if.seg2, s_if.seg3}
                                : {u_if.seg1, u_if.seg2, u_if.seg3};
          dn_neg[dn_cnt]  = sel ? s_if.neg : u_if.neg;
        end
        dn_cnt++;
      end
      if (i > t0 && !b && busy_drop < 0) busy_drop = i;
      vld = (i == t0) || (i == t1) || (i == t2);
      val = (i == t2) ? v2 : (i == t1) ? v1 : v0;
      u_if.acc_valid = vld && !sel;
      s_if.acc_valid = vld && sel;
      u_if.acc_value = val;
      s_if.acc_value = val;
    end
    u_if.acc_valid = 1'b0;
    s_if.acc_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'd255, 1'b0, 255, {7'h24, 7'h12, 7'h12}};
    vecs[1]  = '{8'd0,   1'b0, 0,   {7'h40, 7'h40, 7'h40}};
    vecs[2]  = '{8'd7,   1'b0, 7,   {7'h40, 7'h40, 7'h78}};
    vecs[3]  = '{8'd42,  1'b0, 42,  {7'h40, 7'h19, 7'h24}};
    vecs[4]  = '{8'd100, 1'b0, 100, {7'h79, 7'h40, 7'h40}};
    vecs[5]  = '{8'd199, 1'b0, 199, {7'h79, 7'h10, 7'h10}};
    vecs[6]  = '{8'd128, 1'b0, 128, {7'h79, 7'h24, 7'h00}};
    vecs[7]  = '{8'd9,   1'b0, 9,   {7'h40, 7'h40, 7'h10}};
    vecs[8]  = '{8'd63,  1'b0, 63,  {7'h40, 7'h02, 7'h30}};
    vecs[9]  = '{8'd250, 1'b0, 250, {7'h24, 7'h12, 7'h40}};
    vecs[10] = '{8'd86,  1'b0, 86,  {7'h40, 7'h00, 7'h02}};

    svecs[0] = '{8'h80, 1'b1, 128, {7'h79, 7'h24, 7'h00}};
    svecs[1] = '{8'hFF, 1'b1, 1,   {7'h40, 7'h40, 7'h79}};
    svecs[2] = '{8'h81, 1'b1, 127, {7'h79, 7'h24, 7'h78}};
    svecs[3] = '{8'h05, 1'b0, 5,   {7'h40, 7'h40, 7'h12}};
    svecs[4] = '{8'h7F, 1'b0, 127, {7'h79, 7'h24, 7'h78}};

    rst_n          = 1'b0;
    u_if.acc_valid = 1'b0;
    u_if.acc_value = '0;
    s_if.acc_valid = 1'b0;
    s_if.acc_value = '0;
    repeat (3) @(negedge clk);
    check("reset_segs", {u_if.seg1, u_if.seg2, u_if.seg3}, {7'h7F, 7'h7F, 7'h7F});
    check("reset_status", {u_if.busy, u_if.done, u_if.neg}, 3'b000);
    check("reset_s_status", {s_if.busy, s_if.done, s_if.neg}, 3'b000);
    rst_n = 1'b1;

    // Single conversions: digits, latency, busy window and one-cycle done.
    foreach (vecs[k]) begin
      run_sched(1'b0, 0, vecs[k].val, -1, 8'd0, -1, 8'd0, 14);
      check($sformatf("vec%0d_done_cnt", k), dn_cnt, 1);
      check($sformatf("vec%0d_segs", k), dn_segs[0], exp_segs(vecs[k].segs, vecs[k].mag));
      check($sformatf("vec%0d_latency", k), dn_cyc[0], 10);
      check($sformatf("vec%0d_busy_drop", k), busy_drop, 10);
      check($sformatf("vec%0d_neg", k), dn_neg[0], 1'b0);
    end

    // Queued strobes during SHIFT: last one wins, chained without an idle cycle.
    run_sched(1'b0, 0, 8'd7, 3, 8'd42, 5, 8'd199, 30);
    check("queue_done_cnt", dn_cnt, 2);
    check("queue_first_segs", dn_segs[0], exp_segs({7'h40, 7'h40, 7'h78}, 7));
    check("queue_second_segs", dn_segs[1], {7'h79, 7'h10, 7'h10});
    check("queue_first_cyc", dn_cyc[0], 10);
    check("queue_second_cyc", dn_cyc[1], 19);
    check("queue_busy_drop", busy_drop, 19);

    // Strobe on the UPDATE edge overrides an already-pending value.
    run_sched(1'b0, 0, 8'd255, 3, 8'd42, 9, 8'd100, 30);
    check("collide_done_cnt", dn_cnt, 2);
    check("collide_first_segs", dn_segs[0], {7'h24, 7'h12, 7'h12});
    check("collide_second_segs", dn_segs[1], {7'h79, 7'h40, 7'h40});
    check("collide_second_cyc", dn_cyc[1], 19);

    // Reset partway through converting 128.
    @(negedge clk);
    u_if.acc_value = 8'd128;
    u_if.acc_valid = 1'b1;
    @(negedge clk);
    u_if.acc_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_segs", {u_if.seg1, u_if.seg2, u_if.seg3}, {7'h7F, 7'h7F, 7'h7F});
    check("midrst_status", {u_if.busy, u_if.done}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    run_sched(1'b0, -1, 8'd0, -1, 8'd0, -1, 8'd0, 15);
    check("midrst_no_done", dn_cnt, 0);
    check("midrst_hold_blank", {u_if.seg1, u_if.seg2, u_if.seg3}, {7'h7F, 7'h7F, 7'h7F});
    check("midrst_busy_idle", u_if.busy, 1'b0);
    run_sched(1'b0, 0, 8'd9, -1, 8'd0, -1, 8'd0, 14);
    check("postrst_seg3", dn_segs[0][6:0], 7'h10);
    check("postrst_latency", dn_cyc[0], 10);

    // Signed instance: magnitude digits and sign flag.
    foreach (svecs[k]) begin
      run_sched(1'b1, 0, svecs[k].val, -1, 8'd0, -1, 8'd0, 14);
      check($sformatf("svec%0d_done_cnt", k), dn_cnt, 1);
      check($sformatf("svec%0d_segs", k), dn_segs[0], exp_segs(svecs[k].segs, svecs[k].mag));
      check($sformatf("svec%0d_neg", k), dn_neg[0], svecs[k].neg);
      check($sformatf("svec%0d_latency", k), dn_cyc[0], 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
